// File: rtl/rssb_pkg.sv
// Shared types, default widths and helpers for the RSSB core.
package rssb_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  // All-ones address of the given width; an instruction holding it halts the core.
  function automatic logic [63:0] halt_addr(input int unsigned width);
    if (width >= 64) halt_addr = '1;
    else             halt_addr = (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/rssb_sub.sv
// Reverse-subtract datapath: result = minuend - subtrahend, borrow when minuend < subtrahend.
module rssb_sub
  import rssb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] result,
  output logic             borrow
);

  logic [WIDTH:0] diff;

  // One extra bit carries the unsigned borrow out of the subtraction.
  assign diff   = {1'b0, minuend} - {1'b0, subtrahend};
  assign result = diff[WIDTH-1:0];
  assign borrow = diff[WIDTH];

endmodule

// File: rtl/rssb_ctrl.sv
// RSSB sequencing controller: fetch / decode / execute over external ROM and RAM.
module rssb_ctrl
  import rssb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_we,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [WIDTH-1:0] HALT_A = WIDTH'(halt_addr(WIDTH));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pc, acc, opnd;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result;
  logic             borrow;

  rssb_sub #(.WIDTH(WIDTH)) u_sub (
    .minuend   (ram_rdata),
    .subtrahend(acc),
    .result    (result),
    .borrow    (borrow)
  );

  // State register plus architectural registers (pc, acc, operand, retire count).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc  <= '0;
            acc <= '0;
            cnt <= '0;
          end
        end
        DECODE: opnd <= rom_data;
        EXEC: begin
          acc <= result;
          pc  <= pc + (borrow ? WIDTH'(2) : WIDTH'(1));
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and RAM port control; reset blanks the RAM port in the same cycle.
  always_comb begin
    state_nx  = state;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (state)
      IDLE, HALT: if (start) state_nx = FETCH;
      FETCH:      state_nx = DECODE;
      DECODE: begin
        if (rom_data == HALT_A) begin
          state_nx = HALT;
        end else begin
          ram_addr = rom_data;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        ram_addr  = opnd;
        ram_wdata = result;
        ram_we    = 1'b1;
        state_nx  = FETCH;
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
    end
  end

  assign rom_addr  = pc;
  assign pc_out    = pc;
  assign acc_out   = acc;
  assign instr_cnt = cnt;
  assign busy      = (state == FETCH) || (state == DECODE) || (state == EXEC);
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_rssb_ctrl.sv
// Scoreboard bench for rssb_ctrl with 1-cycle-latency ROM/RAM models.
module tb_rssb_ctrl;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] acc;
    logic [7:0] pc;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_cmd, noise_en, start, start2;
  logic [7:0]  rom_addr, rom_data, ram_addr, ram_rdata, ram_wdata, acc_out, pc_out;
  logic        ram_we, busy, halted;
  logic [15:0] instr_cnt;
  logic [7:0]  rom_addr2, rom_data2, ram_addr2, ram_rdata2, ram_wdata2, acc_out2, pc_out2;
  logic        ram_we2, busy2, halted2;
  logic [1:0]  instr_cnt2;

  logic [7:0]  rom  [256];
  logic [7:0]  ram  [256];
  logic [7:0]  ram2 [256];
  logic        ld_we;
  logic [7:0]  ld_a, ld_d;
  logic        watch_en, saw2, mon_en;

  wr_t q[$];
  wr_t mon_e;
  int  ncmp = 0, nfail = 0, n_done = 0;

  // Stray start pulses whenever the core is busy; they must be ignored.
  assign start = start_cmd | (noise_en & busy);

  rssb_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .acc_out(acc_out), .pc_out(pc_out), .busy(busy), .halted(halted), .instr_cnt(instr_cnt)
  );

  rssb_ctrl #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .ram_addr(ram_addr2), .ram_rdata(ram_rdata2), .ram_wdata(ram_wdata2), .ram_we(ram_we2),
    .acc_out(acc_out2), .pc_out(pc_out2), .busy(busy2), .halted(halted2), .instr_cnt(instr_cnt2)
  );

  // Synchronous ROM shared by both instances.
  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data2 <= rom[rom_addr2];
  end

  // Synchronous RAMs; the bench load port writes both when the core is not writing.
  always @(posedge clk) begin
    if (ram_we)     ram[ram_addr] <= ram_wdata;
    else if (ld_we) ram[ld_a]     <= ld_d;
    if (ram_we2)    ram2[ram_addr2] <= ram_wdata2;
    else if (ld_we) ram2[ld_a]      <= ld_d;
    ram_rdata  <= ram[ram_addr];
    ram_rdata2 <= ram2[ram_addr2];
  end

  // Sticky flag: rom_addr visited address 2 while watching.
  always @(negedge clk) saw2 <= watch_en ? (saw2 | (rom_addr == 8'd2)) : 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every RAM write pops the next expected write, then checks acc/pc after it.
  always begin
    @(negedge clk);
    if (mon_en && ram_we) begin
      if (q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_wdata);
      end else begin
        mon_e = q.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(ram_wdata), 32'(mon_e.wdata));
        @(negedge clk);
        chk("acc_after", 32'(acc_out), 32'(mon_e.acc));
        chk("pc_after", 32'(pc_out), 32'(mon_e.pc));
        n_done++;
      end
    end
  end

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] ac,
                        input logic [7:0] p);
    q.push_back({a, d, ac, p});
  endtask

  task automatic ld(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // Pulse start for one edge; the next cycle must be FETCH with cleared registers.
  task automatic pulse_start();
    @(negedge clk);
    start_cmd = 1'b1;
    @(posedge clk);
    #1 start_cmd = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_pc", 32'(pc_out), 32'h0);
    chk("start_acc", 32'(acc_out), 32'h0);
    chk("start_cnt", 32'(instr_cnt), 32'h0);
  endtask

  // Count cycles (FETCH of first instruction = cycle 0) until halted.
  task automatic wait_halt(input int exp_cyc);
    int cyc = 0;
    while (!halted && cyc <= 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("halt_cycle", 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic wait_done(input int target, input int bound);
    int c = 0;
    while (n_done < target && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk("drain_count", 32'(n_done), 32'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_wrap(input logic [7:0] last_val);
    for (int i = 0; i < 254; i++) rom[i] = 8'h80;
    rom[254] = 8'h81;
    rom[255] = 8'h82;
    ld(8'h80, 8'h00);
    ld(8'h81, 8'h05);
    ld(8'h82, last_val);
    n_done = 0;
    for (int i = 0; i < 254; i++) exp_wr(8'h80, 8'h00, 8'h00, 8'(i + 1));
    exp_wr(8'h81, 8'h05, 8'h05, 8'hFF);
  endtask

  initial begin
    rst = 1'b1; start_cmd = 1'b0; start2 = 1'b0; noise_en = 1'b0;
    ld_we = 1'b0; ld_a = '0; ld_d = '0; watch_en = 1'b0; mon_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_acc", 32'(acc_out), 32'h0);
    chk("rst_cnt", 32'(instr_cnt), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_halted2", 32'(halted2), 32'h0);

    // Basic sequence: 10-0=10, then 10-10=0, halt at pc 2.
    rom[0] = 8'h05; rom[1] = 8'h05; rom[2] = 8'hFF;
    ld(8'h05, 8'd10);
    exp_wr(8'h05, 8'd10, 8'd10, 8'h01);
    exp_wr(8'h05, 8'd0, 8'd0, 8'h02);
    pulse_start();
    wait_halt(8);
    chk("basic_pc", 32'(pc_out), 32'h2);
    chk("basic_acc", 32'(acc_out), 32'h0);
    chk("basic_cnt", 32'(instr_cnt), 32'h2);
    chk("basic_ram5", 32'(ram[5]), 32'h0);
    chk("basic_queue", 32'(q.size()), 32'h0);

    // Borrow skip from HALT: 3-7 borrows, pc 1->3 lands on the halt word.
    rom[0] = 8'h07; rom[1] = 8'h06; rom[2] = 8'h55; rom[3] = 8'hFF;
    ld(8'h07, 8'd7);
    ld(8'h06, 8'd3);
    exp_wr(8'h07, 8'h07, 8'h07, 8'h01);
    exp_wr(8'h06, 8'hFC, 8'hFC, 8'h03);
    noise_en = 1'b1;
    pulse_start();
    watch_en = 1'b1;
    wait_halt(8);
    noise_en = 1'b0;
    chk("skip_pc", 32'(pc_out), 32'h3);
    chk("skip_acc", 32'(acc_out), 32'hFC);
    chk("skip_cnt", 32'(instr_cnt), 32'h2);
    chk("skip_ram6", 32'(ram[6]), 32'hFC);
    chk("skip_ram7", 32'(ram[7]), 32'h07);
    chk("skip_rom2_fetched", 32'(saw2), 32'h0);
    chk("skip_queue", 32'(q.size()), 32'h0);
    watch_en = 1'b0;

    // PC wrap with borrow: 0xFF + 2 -> 0x01.
    load_wrap(8'h02);
    exp_wr(8'h82, 8'hFD, 8'hFD, 8'h01);
    noise_en = 1'b1;
    pulse_start();
    wait_done(256, 1000);
    noise_en = 1'b0;
    do_reset();
    chk("wrap_b_queue", 32'(q.size()), 32'h0);
    q.delete();

    // PC wrap without borrow: 0xFF + 1 -> 0x00.
    load_wrap(8'h09);
    exp_wr(8'h82, 8'h04, 8'h04, 8'h00);
    pulse_start();
    wait_done(256, 1000);
    do_reset();
    chk("wrap_nb_queue", 32'(q.size()), 32'h0);
    q.delete();

    // Reset during EXEC suppresses the write and returns to IDLE.
    mon_en = 1'b0;
    rom[0] = 8'h90;
    ld(8'h90, 8'h33);
    pulse_start();
    @(negedge clk);
    chk("dec_ram_addr", 32'(ram_addr), 32'h90);
    chk("dec_ram_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    chk("exec_ram_we", 32'(ram_we), 32'h1);
    chk("exec_ram_wdata", 32'(ram_wdata), 32'h33);
    rst = 1'b1;
    #1;
    chk("rst_exec_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_halted", 32'(halted), 32'h0);
    chk("mid_pc", 32'(pc_out), 32'h0);
    chk("mid_acc", 32'(acc_out), 32'h0);
    chk("mid_cnt", 32'(instr_cnt), 32'h0);
    chk("mid_ram_addr", 32'(ram_addr), 32'h0);
    chk("mid_ram_wdata", 32'(ram_wdata), 32'h0);
    chk("mid_ram90", 32'(ram[8'h90]), 32'h33);

    // rst together with start stays in IDLE.
    @(negedge clk);
    rst = 1'b1; start_cmd = 1'b1;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy), 32'h0);
    rst = 1'b0; start_cmd = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", 32'(busy), 32'h0);

    // Two-bit retire counter saturates at 3 over five instructions.
    for (int i = 0; i < 5; i++) rom[i] = 8'hA0;
    rom[5] = 8'hFF;
    ld(8'hA0, 8'h00);
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    begin
      int cyc = 0;
      while (!halted2 && cyc <= 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("sat_halt_cycle", 32'(cyc), 32'd17);
    end
    chk("sat_cnt", 32'(instr_cnt2), 32'h3);
    chk("sat_pc", 32'(pc_out2), 32'h5);
    chk("sat_acc", 32'(acc_out2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/rssb_ctrl.md
# rssb_ctrl

Sequencing controller for the RSSB (reverse-subtract, skip-if-borrow) core. It owns the program counter, accumulator and operand register, and drives the instruction ROM and data RAM through fetch, decode and execute. Each instruction is one ROM word holding a data address A. Execution computes `mem[A] - acc`, writes the result to both `mem[A]` and `acc`, and advances the PC by 2 on borrow and by 1 otherwise.

## Interface
Parameters:
- `WIDTH`, 8, data, address and PC width.
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`, input, 1, the single clock; all state changes on its rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `start`, input, 1, begins execution when the state is IDLE or HALT.
- `rom_addr`, output, WIDTH, instruction ROM address (the PC).
- `rom_data`, input, WIDTH, ROM word; valid one cycle after `rom_addr`.
- `ram_addr`, output, WIDTH, data RAM address.
- `ram_rdata`, input, WIDTH, RAM read data; valid one cycle after `ram_addr` when `ram_we`=0.
- `ram_wdata`, output, WIDTH, RAM write data.
- `ram_we`, output, 1, RAM write enable; the write commits on the rising edge.
- `acc_out`, output, WIDTH, accumulator value.
- `pc_out`, output, WIDTH, program counter value.
- `busy`, output, 1, high in FETCH, DECODE and EXEC.
- `halted`, output, 1, high in HALT.
- `instr_cnt`, output, CNT_W, retired-instruction count; saturates at all-ones.

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, HALT.
- **IDLE:** hold state. On `start`: pc ← 0, acc ← 0, instr_cnt ← 0, go to FETCH.
- **FETCH:** `rom_addr` = pc, which is driven in every state. Go to DECODE.
- **DECODE:** `rom_data` is valid and is latched into opnd.
  - If `rom_data` == HALT_ADDR (all-ones), go to HALT. No RAM access, and pc is unchanged so it still points at the halt word.
  - Otherwise drive `ram_addr` = `rom_data` combinationally with `ram_we`=0, and go to EXEC.
- **EXEC:** `ram_rdata` is valid.
  - Compute diff = {1'b0, ram_rdata} − {1'b0, acc}, WIDTH+1 bits. result = diff[WIDTH-1:0]; borrow = diff[WIDTH], i.e. set when ram_rdata < acc, unsigned.
  - Drive `ram_addr` = opnd, `ram_wdata` = result, `ram_we` = 1.
  - Update registers: acc ← result; pc ← pc + (borrow ? 2 : 1), modulo 2^WIDTH; instr_cnt ← instr_cnt + 1 unless it is already all-ones.
  - Go to FETCH.
- **HALT:** hold state. On `start`, restart exactly as from IDLE.
- **`start` in other states:** ignored in FETCH, DECODE and EXEC.
- **Self-reference:** an operand of 0 or any other address is ordinary RAM. There are no memory-mapped PC or accumulator locations.
- **Boundary cases:**
  - PC wrap: 0xFF+1 → 0x00 and 0xFF+2 → 0x01 for WIDTH=8.
  - A skip landing on the halt word still halts.
  - Result 0 with no borrow advances by 1.
- **Reset:** `rst` wins over `start`. Asserting `rst` in any state, including mid-EXEC, suppresses that cycle's `ram_we` and forces IDLE.

## Timing
- **Reset values:** state=IDLE, pc=0, acc=0, opnd=0, instr_cnt=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `busy`=0, `halted`=0, `rom_addr`=0.
- **Instruction latency:** exactly 3 cycles (FETCH, DECODE, EXEC). Throughput is one instruction per 3 cycles.
- **Start-up:** FETCH of the first instruction occurs in the cycle after `start` is sampled.
- **Halt:** `halted` rises the cycle after DECODE sees HALT_ADDR. A program of N instructions followed by a halt takes 3N+2 cycles from FETCH to HALT.
- **Outputs outside DECODE/EXEC:** `ram_we`=0 and `ram_addr`=0. `ram_wdata`=0 outside EXEC.
- **Register outputs:** `acc_out`, `pc_out` and `instr_cnt` are registered and update at the end of EXEC.

## Structure
- **`rssb_pkg`:**
  - `state_t` enum, `logic [2:0]`: IDLE, FETCH, DECODE, EXEC, HALT.
  - Function `halt_addr(width)` returning all-ones.
  - Default widths.
- **Sub-module `rssb_sub`:** combinational reverse-subtract producing result and borrow. It is the only sub-module.
- **Controller:** one always_ff for state and registers, one always_comb for next state and memory controls.

## Test plan
Use WIDTH=8 with behavioural 1-cycle-latency ROM/RAM models.
- **Basic sequence:** ROM={5,5,FF}, RAM[5]=10, then `start` → acc=10 with RAM[5]=10, pc=1; then acc=0, RAM[5]=0, pc=2; `halted`=1 and instr_cnt=2 at cycle 8 after FETCH.
- **Borrow skip:** ROM={7,6,X,FF}, RAM[7]=7, RAM[6]=3 → after instr 2, acc=0xFC and RAM[6]=0xFC. pc jumps 1→3, so ROM[2] is never fetched (check `rom_addr` never equals 2); then halt.
- **PC wrap:** preload pc=0xFF via a program at 0xFE, with ROM[0xFF] an operand producing a borrow → pc=0x01. Without a borrow → pc=0x00.
- **Reset mid-EXEC:** assert `rst` during EXEC → no RAM write (RAM value unchanged), next cycle state=IDLE and all outputs at reset values. `rst`+`start` together → IDLE.
- **Restart from HALT:** pulse `start` while `halted` → pc=0, acc=0, instr_cnt=0, FETCH next cycle. `start` pulses during FETCH/DECODE/EXEC have no effect.
- **Counter saturation:** CNT_W=2 with a 5-instruction loop-free program → instr_cnt sticks at 3.
